// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and constants for the matrix-keypad scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } frame_kind_t;

    // Key index is fixed at 8 bits so the package stays geometry-agnostic.
    typedef logic [7:0] key_idx_t;

    typedef struct packed {
        frame_kind_t kind;
        key_idx_t    code;
    } frame_res_t;

    localparam logic [1:0] c_st_drive   = 2'd0;
    localparam logic [1:0] c_st_sample  = 2'd1;
    localparam logic [1:0] c_st_advance = 2'd2;

    // Element 0 is row 0 / column 0; rows run 1 2 3 A, 4 5 6 B, 7 8 9 C, 0 F E D.
    localparam logic [15:0][3:0] c_keymap_4x4 = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    localparam int c_repeat_hold_frames   = 128;
    localparam int c_repeat_period_frames = 32;

    function automatic logic [3:0] keymap_value(input key_idx_t code, input int rows, input int cols);
        if (rows == 4 && cols == 4) begin
            return c_keymap_4x4[code[3:0]];
        end
        return code[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
// Module      : keypad_debounce
// Description : Frame-level debouncer producing the debounced key state and a
//               press strobe. Optional auto-repeat under KEYPAD_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_frame_valid,
    input  frame_res_t i_frame,
    output logic       o_held,
    output logic       o_event,
    output key_idx_t   o_event_code
);

    frame_res_t r_cand;
    frame_res_t r_deb;
    logic [3:0] r_match;

    frame_res_t w_cand_next;
    frame_res_t w_deb_next;
    logic [3:0] w_match_next;
    logic       w_same;
    logic       w_accept;
    logic       w_press;

    always_comb begin
        w_same       = (i_frame.kind == r_cand.kind) &&
                       (i_frame.kind != RES_KEY || i_frame.code == r_cand.code);
        w_cand_next  = r_cand;
        w_match_next = r_match;
        if (i_frame_valid) begin
            if (i_frame.kind == RES_MULTI) begin
                w_match_next = 4'd0;
            end else if (w_same) begin
                w_match_next = (r_match == 4'hF) ? r_match : r_match + 4'd1;
            end else begin
                w_cand_next  = i_frame;
                w_match_next = 4'd1;
            end
        end
        w_accept   = i_frame_valid && (i_frame.kind != RES_MULTI) &&
                     (w_match_next >= 4'(DEBOUNCE_SCANS));
        w_deb_next = w_accept ? w_cand_next : r_deb;
        // A press is any move into a key other than the one already held.
        w_press    = w_accept && (w_cand_next.kind == RES_KEY) &&
                     !(r_deb.kind == RES_KEY && r_deb.code == w_cand_next.code);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand  <= '0;
            r_deb   <= '0;
            r_match <= 4'd0;
        end else begin
            r_cand  <= w_cand_next;
            r_deb   <= w_deb_next;
            r_match <= w_match_next;
        end
    end

    assign o_held       = (r_deb.kind == RES_KEY);
    assign o_event_code = w_deb_next.code;

`ifdef KEYPAD_REPEAT_EN
    logic [7:0] r_rep_cnt;
    logic [7:0] w_rep_next;
    logic       w_repeat;

    // Counter restarts on every press; after the first repeat it is rewound so
    // later repeats are a period apart instead of a full hold time.
    always_comb begin
        w_repeat   = 1'b0;
        w_rep_next = r_rep_cnt;
        if (i_frame_valid) begin
            if (w_press || w_deb_next.kind != RES_KEY) begin
                w_rep_next = 8'd0;
            end else if (r_rep_cnt == 8'(c_repeat_hold_frames - 1)) begin
                w_repeat   = 1'b1;
                w_rep_next = 8'(c_repeat_hold_frames - c_repeat_period_frames);
            end else begin
                w_rep_next = r_rep_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt <= 8'd0;
        end else begin
            r_rep_cnt <= w_rep_next;
        end
    end

    assign o_event = w_press | w_repeat;
`else
    assign o_event = w_press;
`endif

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : Matrix-keypad column sequencer, row capture and press-event
//               register. Optional auto-repeat: define KEYPAD_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_TICKS     = 100000,
    parameter int SETTLE_TICKS   = 8,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ROWS-1:0]                 row,
    output logic [COLS-1:0]                 col,
    output logic                            key_valid,
    input  logic                            key_ready,
    output logic [$clog2(ROWS*COLS)-1:0]    key_code,
    output logic [3:0]                      key_value,
    output logic                            key_held,
    output logic                            key_overrun
);

    localparam int CODE_W = $clog2(ROWS * COLS);
    localparam int CNT_W  = $clog2(SCAN_TICKS + 1);
    localparam int CIDX_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic                       r_active;
    logic [1:0]                 r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [CIDX_W-1:0]          r_cidx;
    logic [COLS-1:0]            r_col;
    logic [COLS-1:0][ROWS-1:0]  r_frame;

    logic [CNT_W-1:0]           w_cnt_next;
    logic [CIDX_W-1:0]          w_cidx_next;
    logic                       w_frame_done;
    frame_res_t                 w_res;

    logic                       w_held;
    logic                       w_evt;
    key_idx_t                   w_evt_code;

    logic                       r_valid;
    logic [CODE_W-1:0]          r_code;
    logic [3:0]                 r_value;
    logic                       r_overrun;

    function automatic logic [1:0] state_for(input logic [CNT_W-1:0] cnt);
        if (cnt == CNT_W'(SCAN_TICKS - 1)) return c_st_advance;
        if (cnt == CNT_W'(SETTLE_TICKS))   return c_st_sample;
        return c_st_drive;
    endfunction

    function automatic logic [COLS-1:0] col_drive(input logic [CIDX_W-1:0] idx);
        logic [COLS-1:0] v;
        v      = '1;
        v[idx] = 1'b0;
        return v;
    endfunction

    always_comb begin
        w_cnt_next   = (r_state == c_st_advance) ? '0 : r_cnt + CNT_W'(1);
        w_cidx_next  = r_cidx;
        if (r_state == c_st_advance) begin
            w_cidx_next = (r_cidx == CIDX_W'(COLS - 1)) ? '0 : r_cidx + CIDX_W'(1);
        end
        w_frame_done = r_active && (r_state == c_st_advance) &&
                       (r_cidx == CIDX_W'(COLS - 1));
    end

    // Columns stay released for the reset cycle; scanning starts on the first
    // edge after rst falls, with the counter still at zero for column 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_state  <= c_st_drive;
            r_cnt    <= '0;
            r_cidx   <= '0;
            r_col    <= '1;
            r_frame  <= '0;
        end else if (!r_active) begin
            r_active <= 1'b1;
            r_state  <= state_for('0);
            r_col    <= col_drive('0);
        end else begin
            r_cnt    <= w_cnt_next;
            r_state  <= state_for(w_cnt_next);
            r_cidx   <= w_cidx_next;
            r_col    <= col_drive(w_cidx_next);
            if (r_cnt == CNT_W'(SETTLE_TICKS)) begin
                r_frame[r_cidx] <= ~row;
            end
        end
    end

    always_comb begin
        int hits;
        hits       = 0;
        w_res.kind = RES_NONE;
        w_res.code = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (r_frame[c][r]) begin
                    hits       = hits + 1;
                    w_res.code = key_idx_t'(r * COLS + c);
                end
            end
        end
        if (hits == 1) begin
            w_res.kind = RES_KEY;
        end else if (hits > 1) begin
            w_res.kind = RES_MULTI;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk           (clk),
        .rst           (rst),
        .i_frame_valid (w_frame_done),
        .i_frame       (w_res),
        .o_held        (w_held),
        .o_event       (w_evt),
        .o_event_code  (w_evt_code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_code    <= '0;
            r_value   <= 4'd0;
            r_overrun <= 1'b0;
        end else if (w_evt) begin
            if (!r_valid || key_ready) begin
                r_valid <= 1'b1;
                r_code  <= w_evt_code[CODE_W-1:0];
                r_value <= keymap_value(w_evt_code, ROWS, COLS);
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && key_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign col         = r_col;
    assign key_valid   = r_valid;
    assign key_code    = r_code;
    assign key_value   = r_value;
    assign key_held    = w_held;
    assign key_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Directed self-checking bench for keypad_scanner (4x4, short scan).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int FRAME = 64;

    logic        clk;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic        key_ready;
    logic [3:0]  key_code;
    logic [3:0]  key_value;
    logic        key_held;
    logic        key_overrun;
    logic [15:0] keys;

    int n_checks;
    int n_fail;

    keypad_scanner #(
        .ROWS           (4),
        .COLS           (4),
        .SCAN_TICKS     (16),
        .SETTLE_TICKS   (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row         (row),
        .col         (col),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_code    (key_code),
        .key_value   (key_value),
        .key_held    (key_held),
        .key_overrun (key_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int k = 0; k < 16; k++) begin
            if (keys[k] && !col[k % 4]) row[k / 4] = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            check("quiet_valid", key_valid, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [3:0] exp_col;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        keys      = 16'h0000;
        key_ready = 1'b0;
        step(3);
        check("rst_col", col, 4'hF);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        check("rst_overrun", key_overrun, 0);
        check("rst_code", key_code, 0);
        check("rst_value", key_value, 0);

        // Scan sequence, no key pressed
        rst = 1'b0;
        step(1);
        for (int i = 0; i < FRAME; i++) begin
            exp_col = 4'hF;
            exp_col[i / 16] = 1'b0;
            check("scan_col", col, exp_col);
            check("scan_valid", key_valid, 0);
            step(1);
        end

        // Single press: key 6 (row 1, column 2)
        keys = 16'h0040;
        quiet(3 * FRAME);
        check("press_valid", key_valid, 1);
        check("press_code", key_code, 6);
        check("press_value", key_value, 4'h6);
        check("press_held", key_held, 1);
        key_ready = 1'b1;
        step(1);
        check("press_accept_fall", key_valid, 0);
        quiet(FRAME - 1);
        keys = 16'h0000;
        quiet(3 * FRAME);
        check("release_held", key_held, 0);
        key_ready = 1'b0;

        // Bounce on key 0: 2 frames on, 1 off, 3 on
        keys = 16'h0001;
        quiet(2 * FRAME);
        keys = 16'h0000;
        quiet(FRAME);
        keys = 16'h0001;
        quiet(3 * FRAME);
        check("bounce_valid", key_valid, 1);
        check("bounce_code", key_code, 0);
        check("bounce_value", key_value, 4'h1);
        key_ready = 1'b1;
        step(1);
        key_ready = 1'b0;
        check("bounce_accept_fall", key_valid, 0);
        keys = 16'h0000;
        quiet(FRAME - 1 + 2 * FRAME);
        check("bounce_release_held", key_held, 0);

        // Multi-key: codes 0 and 5 together
        keys = 16'h0021;
        quiet(5 * FRAME);
        check("multi_held", key_held, 0);
        keys = 16'h0000;
        quiet(FRAME);

        // Overrun: key 3 left pending, release, then key 15
        keys = 16'h0008;
        quiet(3 * FRAME);
        check("ovr_first_valid", key_valid, 1);
        check("ovr_first_code", key_code, 3);
        check("ovr_first_value", key_value, 4'hA);
        keys = 16'h0000;
        step(3 * FRAME);
        keys = 16'h8000;
        step(3 * FRAME - 1);
        check("ovr_not_yet", key_overrun, 0);
        step(1);
        check("ovr_flag", key_overrun, 1);
        check("ovr_valid", key_valid, 1);
        check("ovr_code_kept", key_code, 3);
        check("ovr_value_kept", key_value, 4'hA);
        check("ovr_held", key_held, 1);

        // Reset during SAMPLE of column 0 with an event pending
        step(4);
        rst = 1'b1;
        step(1);
        check("mid_rst_col", col, 4'hF);
        check("mid_rst_valid", key_valid, 0);
        check("mid_rst_overrun", key_overrun, 0);
        check("mid_rst_held", key_held, 0);
        check("mid_rst_code", key_code, 0);
        rst = 1'b0;
        step(1);
        check("restart_col", col, 4'hE);

        // Key 15 still held through reset: fresh debounce, keymap value D
        quiet(3 * FRAME);
        check("k15_valid", key_valid, 1);
        check("k15_code", key_code, 15);
        check("k15_value", key_value, 4'hD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
